fir_frame_sequencer: RTL
========================

Name: fir_frame_sequencer

Overview:
- Sequences the 256-sample block FIR low-pass datapath.
- Collects a streamed 8-bit input frame into a frame register array driven onto the filter's parallel input bus.
- Clears the filter, then holds its start strobe until the filter reports ready.
- Streams the filtered frame back out over a valid/ready interface; the next input frame fills while the current output frame drains.

Parameters:
FRAME_LEN, 256, samples per frame; must match the filter frame size.
DATA_W, 8, sample width (unsigned).
TIMEOUT, 1024, maximum cycles in START waiting for filt_rdy before abort.
CNT_W, 16, width of the completed-frame counter.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  input sample valid.
in_data  in  DATA_W  input sample, unsigned.
in_ready  out  1  sequencer can accept an input sample.
filt_rst  out  1  reset to filter (clears its sticky ready and outputs).
filt_start  out  1  filter start strobe (level; filter recomputes every cycle it is high).
filt_in  out  DATA_W x FRAME_LEN  frame register array to filter input bus.
filt_rdy  in  1  filter ready (sticky until filt_rst).
filt_out  in  DATA_W x FRAME_LEN  filter output array (held until filt_rst).
out_valid  out  1  output sample valid.
out_data  out  DATA_W  output sample.
out_last  out  1  marks sample FRAME_LEN-1 of a frame.
out_ready  in  1  downstream accepts the output sample.
busy  out  1  state != IDLE.
timeout_err  out  1  sticky; set on filter timeout; cleared only by rst.
frame_cnt  out  CNT_W  count of frames fully drained; wraps.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE; wr_idx=0, rd_idx=0, frame_full=0, wait_cnt=0, timeout_err=0, frame_cnt=0.
  - filt_in contents are don't-care and are not cleared.
  - After reset: in_ready=1, out_valid=0, out_last=0, busy=0, filt_start=0.
  - filt_rst = rst OR (state==CLEAR), so the filter is held in reset while rst is high.
- Fill path, independent of the FSM:
  - in_ready = !frame_full.
  - A beat is accepted when in_valid && in_ready: filt_in[wr_idx] <= in_data; wr_idx increments.
  - When wr_idx==FRAME_LEN-1 is accepted, wr_idx wraps to 0 and frame_full <= 1.
  - frame_full clears on the START->DRAIN transition (the filter outputs are latched, so the input may change) or on a timeout abort.
  - filt_in never changes while in CLEAR or START, because frame_full=1 there.
- FSM states:
  - IDLE: if frame_full, go to CLEAR.
  - CLEAR: exactly one cycle; filt_rst=1; go to START; wait_cnt <= 0.
  - START: filt_start=1; wait_cnt increments each cycle.
    - If filt_rdy is sampled 1, go to DRAIN with rd_idx <= 0.
    - Else if wait_cnt==TIMEOUT-1, set timeout_err, clear frame_full (frame dropped), go to IDLE.
    - filt_rdy is guaranteed 0 on START entry because of CLEAR.
  - DRAIN: filt_start=0; out_valid=1; out_data=filt_out[rd_idx]; out_last=(rd_idx==FRAME_LEN-1).
    - On out_valid && out_ready, rd_idx increments.
    - On the last beat: frame_cnt increments, go to IDLE.
    - out_data and out_last hold stable while out_ready=0.
- Latency with the single-cycle filter:
  - Last input beat accepted at edge T.
  - IDLE sees frame_full in cycle T+1; CLEAR is cycle T+2; START begins cycle T+3.
  - filt_rdy is sampled high in cycle T+4; DRAIN and out_valid begin cycle T+5.
- Overlap: the next frame may fill fully during DRAIN. IDLE then moves to CLEAR in the cycle after the last output beat. The filter is never reset while DRAIN is reading filt_out.
- Simultaneous events: a final input beat and a final output beat in the same cycle are both honoured. The FSM reaches IDLE and the next cycle goes to CLEAR.
- Reset mid-operation: any state aborts to IDLE. Any partial input and output frames are discarded; frame_cnt is not incremented.

Test Plan:
1. Stream samples 0..255 with out_ready=1, using the filter model → filt_rst is one-cycle high at T+2; filt_start is high from T+3 until filt_rdy; 256 out beats; out_last only on beat 255; frame_cnt=1.
2. Constant input 200 for a full frame → steady-state out_data matches the model for the late frame samples (≈200 after the 49-sample ramp); no beat is lost or duplicated.
3. out_ready toggled 1-0-1 each cycle during DRAIN → each sample held stable while out_ready=0; exactly 256 beats, rd_idx ordered 0..255.
4. Second frame streamed during DRAIN of the first → in_ready drops after 256 accepted beats; CLEAR occurs the cycle after frame 1's last beat; frame_cnt=2; outputs match the model for both frames.
5. Filter model never asserts filt_rdy → after TIMEOUT=1024 START cycles, timeout_err=1, state IDLE, in_ready=1, frame_cnt unchanged.
6. rst pulsed for one cycle at output beat 100 → out_valid=0, busy=0, in_ready=1, frame_cnt unchanged; the next full frame processes normally.

Source files
------------

// File: rtl/fir_frame_sequencer_if.sv
// rtl/fir_frame_sequencer_if.sv - sample streams and filter bus between the sequencer and its environment.
// master is the sequencer side, slave is the source/sink/filter side.
interface fir_frame_sequencer_if #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 256
);
  logic                                 in_valid;
  logic [DATA_W-1:0]                    in_data;
  logic                                 in_ready;
  logic                                 filt_rst;
  logic                                 filt_start;
  logic [FRAME_LEN-1:0][DATA_W-1:0]     filt_in;
  logic                                 filt_rdy;
  logic [FRAME_LEN-1:0][DATA_W-1:0]     filt_out;
  logic                                 out_valid;
  logic [DATA_W-1:0]                    out_data;
  logic                                 out_last;
  logic                                 out_ready;

  modport master (
    input  in_valid, in_data, filt_rdy, filt_out, out_ready,
    output in_ready, filt_rst, filt_start, filt_in, out_valid, out_data, out_last
  );

  modport slave (
    output in_valid, in_data, filt_rdy, filt_out, out_ready,
    input  in_ready, filt_rst, filt_start, filt_in, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fir_frame_sequencer.sv
// rtl/fir_frame_sequencer.sv - frame fill, filter clear/start handshake and output drain for the block FIR.
// The fill path runs independently of the FSM so the next frame loads while the current one drains.
module fir_frame_sequencer #(
  parameter int FRAME_LEN = 256,
  parameter int DATA_W    = 8,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  fir_frame_sequencer_if.master      bus,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [CNT_W-1:0]           frame_cnt
);
  localparam int IDX_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_LEN - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, START, DRAIN} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic               frame_full;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               accept;
  logic               last_in;
  logic               drain_go;
  logic               abort;
  logic               out_fire;

  assign accept       = bus.in_valid && !frame_full;
  assign last_in      = (wr_idx == LAST_IDX);
  assign bus.in_ready = !frame_full;
  assign bus.filt_rst = rst || (state == CLEAR);
  assign busy         = (state != IDLE);
  assign out_fire     = bus.out_valid && bus.out_ready;

  always_comb begin
    state_nxt      = state;
    bus.filt_start = 1'b0;
    bus.out_valid  = 1'b0;
    bus.out_data   = '0;
    bus.out_last   = 1'b0;
    drain_go       = 1'b0;
    abort          = 1'b0;
    case (state)
      IDLE: begin
        if (frame_full) state_nxt = CLEAR;
      end
      CLEAR: begin
        state_nxt = START;
      end
      START: begin
        bus.filt_start = 1'b1;
        if (bus.filt_rdy) begin
          drain_go  = 1'b1;
          state_nxt = DRAIN;
        end else if (wait_cnt == LAST_WAIT) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        bus.out_valid = 1'b1;
        bus.out_data  = bus.filt_out[rd_idx];
        bus.out_last  = (rd_idx == LAST_IDX);
        if (bus.out_ready && bus.out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_idx      <= '0;
      rd_idx      <= '0;
      frame_full  <= 1'b0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) wr_idx <= last_in ? '0 : wr_idx + IDX_W'(1);
      // Filter outputs are latched once ready, so the input frame may be released on entry to DRAIN.
      if (accept && last_in) frame_full <= 1'b1;
      else if (drain_go || abort) frame_full <= 1'b0;
      if (state == CLEAR) wait_cnt <= '0;
      else if (state == START) wait_cnt <= wait_cnt + WAIT_W'(1);
      if (abort) timeout_err <= 1'b1;
      if (drain_go) rd_idx <= '0;
      else if (out_fire) rd_idx <= bus.out_last ? '0 : rd_idx + IDX_W'(1);
      if (out_fire && bus.out_last) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

  // Frame storage carries no reset; its contents are meaningless until a frame is full.
  always_ff @(posedge clk) begin
    if (accept) bus.filt_in[wr_idx] <= bus.in_data;
  end
endmodule
